// File: rtl/commit_unit_pkg.sv
// commit_unit_pkg: temporary-register entry layout, instruction types and commit states
package commit_unit_pkg;
    localparam int ENTRY_W        = 73;
    localparam int RD_MSB         = 72;
    localparam int RD_LSB         = 68;
    localparam int PC_MSB         = 67;
    localparam int PC_LSB         = 36;
    localparam int TYPE_MSB       = 35;
    localparam int TYPE_LSB       = 34;
    localparam int DATA_MSB       = 33;
    localparam int DATA_LSB       = 2;
    localparam int SPEC_VALID_BIT = 1;
    localparam int VALID_BIT      = 0;

    typedef enum logic [1:0] {ALU = 2'b00, STORE = 2'b01, BRANCH = 2'b10, OTHER = 2'b11} inst_type_t;
    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;
endpackage

// File: rtl/commit_ptr.sv
// commit_ptr: modulo-2^W pointer with synchronous clear and increment
module commit_ptr #(
    parameter int W = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);
    always_ff @(posedge clock) begin
        if (reset || clr) ptr <= '0;
        else if (inc) ptr <= ptr + W'(1);
    end
endmodule

// File: rtl/commit_unit.sv
// commit_unit: in-order retirement from the temporary register file into the ARF.
// Optional macro COMMIT_STATS_EN adds the retired_cnt statistics port.
module commit_unit
    import commit_unit_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int TAG_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               alloc_req,
    output logic               alloc_grant,
    output logic [TAG_W-1:0]   alloc_tag,
    output logic [TAG_W-1:0]   rd_addr,
    input  logic [ENTRY_W-1:0] rd_data,
    input  logic               flush,
    output logic               arf_we,
    output logic [4:0]         arf_waddr,
    output logic [31:0]        arf_wdata,
    output logic               retire_valid,
    output logic [TAG_W-1:0]   retire_tag,
    output logic [31:0]        retire_pc,
    output logic [1:0]         retire_type,
    output logic               empty,
    output logic               full,
    output logic [TAG_W:0]     count
`ifdef COMMIT_STATS_EN
    ,
    output logic [31:0]        retired_cnt
`endif
);
    localparam logic [TAG_W:0] CAP = (TAG_W+1)'(DEPTH);

    state_t           state;
    logic             run;
    logic             retire;
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;

    assign run         = (state == RUN);
    // flush wins over both allocation and retirement in the same cycle
    assign alloc_grant = alloc_req && run && !flush && (count < CAP);
    assign retire      = run && !flush && (count != '0) && rd_data[VALID_BIT] && rd_data[SPEC_VALID_BIT];
    assign alloc_tag   = tail;
    assign rd_addr     = head;
    assign empty       = (count == '0);
    assign full        = (count == CAP);

    commit_ptr #(.W(TAG_W)) u_head (
        .clock (clock),
        .reset (reset),
        .clr   (flush),
        .inc   (retire),
        .ptr   (head)
    );

    commit_ptr #(.W(TAG_W)) u_tail (
        .clock (clock),
        .reset (reset),
        .clr   (flush),
        .inc   (alloc_grant),
        .ptr   (tail)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= RUN;
            count        <= '0;
            retire_valid <= 1'b0;
            arf_we       <= 1'b0;
            arf_waddr    <= '0;
            arf_wdata    <= '0;
            retire_tag   <= '0;
            retire_pc    <= '0;
            retire_type  <= '0;
        end else begin
            state        <= (run && flush) ? FLUSH : RUN;
            count        <= flush ? '0 : count + {{TAG_W{1'b0}}, alloc_grant} - {{TAG_W{1'b0}}, retire};
            retire_valid <= retire;
            arf_we       <= retire && (inst_type_t'(rd_data[TYPE_MSB:TYPE_LSB]) == ALU);
            if (retire) begin
                retire_tag  <= head;
                retire_pc   <= rd_data[PC_MSB:PC_LSB];
                retire_type <= rd_data[TYPE_MSB:TYPE_LSB];
                arf_waddr   <= rd_data[RD_MSB:RD_LSB];
                arf_wdata   <= rd_data[DATA_MSB:DATA_LSB];
            end
        end
    end

`ifdef COMMIT_STATS_EN
    // survives flush; only reset clears it
    always_ff @(posedge clock) begin
        if (reset) retired_cnt <= '0;
        else if (retire) retired_cnt <= retired_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: directed scenarios plus randomized traffic against a queue-occupancy reference model
module tb_commit_unit;
    localparam int DEPTH = 32;
    localparam int TAG_W = 5;

    logic             clock = 1'b0;
    logic             reset;
    logic             alloc_req;
    logic             alloc_grant;
    logic [TAG_W-1:0] alloc_tag;
    logic [TAG_W-1:0] rd_addr;
    logic [72:0]      rd_data;
    logic             flush;
    logic             arf_we;
    logic [4:0]       arf_waddr;
    logic [31:0]      arf_wdata;
    logic             retire_valid;
    logic [TAG_W-1:0] retire_tag;
    logic [31:0]      retire_pc;
    logic [1:0]       retire_type;
    logic             empty;
    logic             full;
    logic [TAG_W:0]   count;
`ifdef COMMIT_STATS_EN
    logic [31:0]      retired_cnt;
`endif

    commit_unit #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .alloc_req    (alloc_req),
        .alloc_grant  (alloc_grant),
        .alloc_tag    (alloc_tag),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .flush        (flush),
        .arf_we       (arf_we),
        .arf_waddr    (arf_waddr),
        .arf_wdata    (arf_wdata),
        .retire_valid (retire_valid),
        .retire_tag   (retire_tag),
        .retire_pc    (retire_pc),
        .retire_type  (retire_type),
        .empty        (empty),
        .full         (full),
        .count        (count)
`ifdef COMMIT_STATS_EN
        ,
        .retired_cnt  (retired_cnt)
`endif
    );

    always #5 clock = ~clock;

    logic [72:0] mem [DEPTH];
    int          m_tail, m_cnt, m_retired;
    bit          m_fl;
    int          n_checks, n_pass;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [72:0] mk(input logic [4:0] rd, input logic [31:0] pc, input logic [1:0] ty,
                                       input logic [31:0] d, input bit sv, input bit v);
        return {rd, pc, ty, d, sv, v};
    endfunction

    function automatic int head_of();
        return (m_tail - m_cnt + DEPTH) % DEPTH;
    endfunction

    // one clock: drive at negedge, check combinational, clock, check registered, advance model
    task automatic step(input bit a, input bit f, input logic [72:0] ne);
        int h;
        bit eg, er;
        logic [72:0] e;
        h = head_of();
        alloc_req = a;
        flush = f;
        rd_data = mem[h];
        #1;
        eg = a && !f && !m_fl && (m_cnt < DEPTH);
        check("alloc_grant", alloc_grant, eg);
        if (eg) check("alloc_tag", alloc_tag, m_tail);
        check("rd_addr", rd_addr, h);
        check("count", count, m_cnt);
        check("empty", empty, m_cnt == 0);
        check("full", full, m_cnt == DEPTH);
        e = mem[h];
        er = !f && !m_fl && (m_cnt > 0) && e[0] && e[1];
        if (eg) mem[m_tail] = ne;
        @(posedge clock);
        #1;
        if (f) begin
            m_tail = 0;
            m_cnt = 0;
        end else begin
            if (eg) begin
                m_tail = (m_tail + 1) % DEPTH;
                m_cnt++;
            end
            if (er) begin
                m_cnt--;
                m_retired++;
            end
        end
        m_fl = f && !m_fl;
        check("retire_valid", retire_valid, er);
        if (er) begin
            check("retire_tag", retire_tag, h);
            check("retire_pc", retire_pc, e[67:36]);
            check("retire_type", retire_type, e[35:34]);
            check("arf_we", arf_we, e[35:34] == 2'b00);
            if (e[35:34] == 2'b00) begin
                check("arf_waddr", arf_waddr, e[72:68]);
                check("arf_wdata", arf_wdata, e[33:2]);
            end
        end else begin
            check("arf_we_idle", arf_we, 0);
        end
`ifdef COMMIT_STATS_EN
        check("retired_cnt", retired_cnt, m_retired);
`endif
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        alloc_req = 1'b1;
        flush = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_tail = 0;
        m_cnt = 0;
        m_fl = 0;
        m_retired = 0;
        check("rst_retire_valid", retire_valid, 0);
        check("rst_arf_we", arf_we, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_retire_tag", retire_tag, 0);
        check("rst_retire_pc", retire_pc, 0);
        check("rst_arf_wdata", arf_wdata, 0);
`ifdef COMMIT_STATS_EN
        check("rst_retired_cnt", retired_cnt, 0);
`endif
        @(negedge clock);
    endtask

    function automatic logic [72:0] rnd_entry();
        return mk(5'($urandom), $urandom, 2'($urandom), $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    endfunction

    initial begin
        n_checks = 0;
        n_pass = 0;
        alloc_req = 1'b0;
        flush = 1'b0;
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        @(negedge clock);
        do_reset();

        // three allocations of not-yet-ready entries
        for (int i = 0; i < 3; i++) step(1, 0, '0);
        check("cnt3", count, 3);
        check("not_empty", empty, 0);

        // ALU head ready
        mem[0] = mk(5'd7, 32'h100, 2'b00, 32'h1234, 1, 1);
        step(0, 0, '0);
        check("arf_waddr7", arf_waddr, 7);
        check("arf_wdata1234", arf_wdata, 32'h1234);

        // spec_valid stall, then release; then a STORE
        mem[1] = mk(5'd3, 32'h104, 2'b00, 32'hbeef, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, '0);
        mem[1][1] = 1'b1;
        step(0, 0, '0);
        mem[2] = mk(5'd9, 32'h108, 2'b01, 32'h5555, 1, 1);
        step(0, 0, '0);
        step(0, 0, '0);

        // fill to full, then request with a ready head
        for (int i = 0; i < DEPTH; i++) step(1, 0, '0);
        check("full_flag", full, 1);
        mem[head_of()] = mk(5'd1, 32'h200, 2'b00, 32'h77, 1, 1);
        step(1, 0, '0);

        // drain/refill traffic through the pointer wrap
        for (int i = 0; i < 200; i++) begin
            mem[head_of()] = mk(5'($urandom), $urandom, 2'($urandom), $urandom, 1, 1);
            step(1, 0, rnd_entry());
        end

        // flush with 10 in flight, alloc requested and head ready
        step(0, 1, '0);
        step(0, 0, '0);
        for (int i = 0; i < 10; i++) step(1, 0, '0);
        mem[head_of()] = mk(5'd2, 32'h300, 2'b00, 32'h99, 1, 1);
        step(1, 1, '0);
        step(1, 0, '0);
        step(1, 0, '0);

        // retire-count then flush
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, mk(5'(i), 32'(i), 2'b10, 32'(i), 1, 1));
        for (int i = 0; i < 5; i++) step(0, 0, '0);
        step(0, 1, '0);
        step(0, 0, '0);

        // randomized traffic with occasional flush and mid-run reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                mem[head_of()][1] = 1'b1;
                mem[head_of()][0] = 1'b1;
            end
            if (i == 1500) do_reset();
            step($urandom_range(0, 9) < 6, $urandom_range(0, 99) < 2, rnd_entry());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/commit_unit.md
COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 Parameter DEPTH, default 32: number of temporary-register entries; SHALL be a power of two.
REQ-002 Parameter TAG_W, default 5: width of entry tags, equal to log2(DEPTH).
REQ-003 One clock; reset is synchronous and active-high. Ports: clock (in, 1, rising-edge clock) and reset (in, 1, synchronous active-high reset).
REQ-004 alloc_req  in  1  dispatch requests a new temporary entry.
REQ-005 alloc_grant  out  1  combinational; high when alloc_req=1, count<DEPTH and state=RUN.
REQ-006 alloc_tag  out  TAG_W  combinational; equals tail pointer; valid when alloc_grant=1.
REQ-007 rd_addr  out  TAG_W  combinational; equals head pointer; read address into the temporary register file.
REQ-008 rd_data  in  73  entry at rd_addr: [72:68] rd_reg, [67:36] PC, [35:34] inst_type, [33:2] spec_data, [1] spec_valid, [0] valid.
REQ-009 flush  in  1  discard all in-flight entries.
REQ-010 arf_we, arf_waddr[4:0], arf_wdata[31:0]  out  architectural register-file write port; registered.
REQ-011 retire_valid  out  1  registered; one entry retired this cycle.
REQ-012 retire_tag[TAG_W-1:0], retire_pc[31:0], retire_type[1:0]  out  registered; describe the retired entry; retire_tag is the freed tag.
REQ-013 empty, full  out  1 each; count  out  TAG_W+1; occupancy.

Function
REQ-014 States: RUN and FLUSH. RUN->FLUSH when flush=1; FLUSH->RUN unconditionally after one cycle.
REQ-015 Allocation SHALL occur when alloc_grant=1 at the rising edge: tail increments modulo DEPTH (DEPTH-1 wraps to 0).
REQ-016 Retire condition, evaluated in RUN at the rising edge: count>0 and rd_data[0]=1 and rd_data[1]=1.
REQ-017 On retire, head SHALL increment modulo DEPTH, and on the next cycle: retire_valid=1, retire_tag=old head, retire_pc=rd_data[67:36], retire_type=rd_data[35:34].
REQ-018 arf_we=1 on the cycle after a retire only when inst_type=2'b00, with arf_waddr=rd_reg and arf_wdata=spec_data; types 01, 10 and 11 SHALL produce no register write.
REQ-019 At most one retire per cycle; back-to-back retires SHALL sustain 1 per cycle.
REQ-020 A head entry with valid=0 or spec_valid=0 SHALL stall retirement, with no output pulse and no pointer change.
REQ-021 count SHALL track allocations and retirements: +1 on alloc only, -1 on retire only, unchanged when both occur in the same cycle.
REQ-022 When full (count=DEPTH), alloc_grant SHALL be 0 even if a retire occurs in the same cycle.
REQ-023 When empty, no retire SHALL occur regardless of rd_data.
REQ-024 flush SHALL take priority over alloc and retire in that cycle: head, tail and count go to 0, and no retire or allocation occurs in that cycle or in the FLUSH cycle.
REQ-025 empty = (count==0); full = (count==DEPTH).

Reset
REQ-026 On reset: state=RUN; head=0, tail=0, count=0; empty=1, full=0; arf_we=0, retire_valid=0; all registered data outputs 0.
REQ-027 Reset mid-operation SHALL discard all entries, with no retire pulse in the following cycle.

Configuration
REQ-028 Macro COMMIT_STATS_EN. When defined, an extra output port retired_cnt (out, 32 bits) SHALL exist: reset to 0, incremented on every retire, wrapping at 2^32, and cleared by reset only (not by flush).
REQ-029 When COMMIT_STATS_EN is undefined, the retired_cnt port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-030 A shared package SHALL hold the entry field bit positions (RD_MSB/LSB, PC_MSB/LSB, TYPE_MSB/LSB, DATA_MSB/LSB, SPEC_VALID_BIT, VALID_BIT), the inst_type encodings (ALU=00, STORE=01, BRANCH=10, OTHER=11) and the state encoding; this is the same package used by the temporary register file.
REQ-031 One sub-module, commit_ptr: a modulo-DEPTH pointer with an increment and a clear input, instantiated twice (head and tail).

Verification
REQ-032 Reset, then 3 allocations -> alloc_tag 0,1,2; count=3; empty=0.
REQ-033 Head entry {rd=7, type=00, data=0x1234, spec_valid=1, valid=1} -> next cycle arf_we=1, arf_waddr=7, arf_wdata=0x1234, retire_tag=0; count decrements.
REQ-034 Head entry with spec_valid=0 for 4 cycles, then set to 1 -> no retire for those 4 cycles, then a single retire pulse; a type=01 entry retires with arf_we=0.
REQ-035 Allocate 32 entries -> full=1, alloc_grant=0 on the 33rd request even with a retire in the same cycle; continued alloc/retire traffic wraps tail 31->0 and head 31->0 correctly.
REQ-036 flush with 10 entries in flight, alloc_req=1 and the head ready -> no retire and no allocation; next cycle count=0, empty=1; after FLUSH, alloc_tag=0.
REQ-037 With COMMIT_STATS_EN defined, 5 retires then a flush -> retired_cnt=5, and it stays 5 after the flush.
